// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between two byte sources, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface uart_tx_arb_if #(
    parameter int CNT_W = 16
);
    logic             s0_valid;
    logic [7:0]       s0_data;
    logic             s0_ready;
    logic             s1_valid;
    logic [7:0]       s1_data;
    logic             s1_ready;
    logic             tx_en;
    logic [7:0]       tx_dat;
    logic             tx_busy;
    logic             active;
    logic             grant_id;
    logic             err_tmo;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, tx_busy,
        output s0_ready, s1_ready, tx_en, tx_dat, active, grant_id, err_tmo, cnt0, cnt1
    );

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, tx_busy,
        input  s0_ready, s1_ready, tx_en, tx_dat, active, grant_id, err_tmo, cnt0, cnt1
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-source round-robin arbiter feeding one UART transmitter, with busy-timeout
// detection and per-source completed-byte counters.
//
//   state     | meaning
//   IDLE      | waiting for a valid source; ready is driven combinationally here
//   LAUNCH    | tx_en high for this one cycle, timeout counter cleared
//   WAIT_BUSY | waiting for the transmitter to raise tx_busy, timing out if it never does
//   WAIT_DONE | byte on the line; completion counted when tx_busy falls
module uart_tx_arb #(
    parameter int BUSY_TMO = 8,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

    state_t     state;
    logic       last_grant;
    logic [7:0] tmo_cnt;
    logic       any_valid;
    logic       pick1;

    // Source 1 wins when it is the only requester, or on a tie when source 0 went last.
    assign any_valid    = bus.s0_valid | bus.s1_valid;
    assign pick1        = bus.s1_valid & (~bus.s0_valid | ~last_grant);
    assign bus.s0_ready = rst_n & (state == IDLE) & bus.s0_valid & ~pick1;
    assign bus.s1_ready = rst_n & (state == IDLE) & pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            tmo_cnt      <= 8'd0;
            bus.tx_en    <= 1'b0;
            bus.tx_dat   <= 8'h00;
            bus.active   <= 1'b0;
            bus.grant_id <= 1'b0;
            bus.err_tmo  <= 1'b0;
            bus.cnt0     <= '0;
            bus.cnt1     <= '0;
        end else begin
            bus.tx_en   <= 1'b0;
            bus.err_tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.tx_dat   <= pick1 ? bus.s1_data : bus.s0_data;
                        bus.grant_id <= pick1;
                        bus.tx_en    <= 1'b1;
                        bus.active   <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= 8'd0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        // Abort on the cycle the count reaches its last value, so
                        // err_tmo lands exactly BUSY_TMO cycles after tx_en.
                        if (tmo_cnt == TMO_LAST - 8'd1) begin
                            bus.err_tmo <= 1'b1;
                            bus.active  <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        bus.active <= 1'b0;
                        last_grant <= bus.grant_id;
                        if (bus.grant_id) bus.cnt1 <= bus.cnt1 + CNT_W'(1);
                        else              bus.cnt0 <= bus.cnt0 + CNT_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter BUSY_TMO, default 8: cycles after tx_en during which tx_busy must rise; range 4..255.
REQ-002 Parameter CNT_W, default 16: width of the per-source byte counters.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low; the block has one clock.
REQ-005 s0_valid  input  1  source 0 has a byte; held until accepted.
REQ-006 s0_data  input  8  source 0 byte; stable while s0_valid=1.
REQ-007 s0_ready  output  1  source 0 byte accepted this cycle.
REQ-008 s1_valid, s1_data, s1_ready: same as source 0, for source 1.
REQ-009 tx_en  output  1  one-cycle launch pulse to the UART transmitter.
REQ-010 tx_dat  output  8  byte to the UART transmitter.
REQ-011 tx_busy  input  1  transmitter busy; rises 2 cycles after tx_en and falls after the stop bit.
REQ-012 active  output  1  a byte is in flight.
REQ-013 grant_id  output  1  source of the in-flight or last byte.
REQ-014 err_tmo  output  1  one-cycle pulse on busy timeout.
REQ-015 cnt0, cnt1  output  CNT_W  bytes completed per source.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE with any valid, the block SHALL select one source, assert only that source's ready combinationally in the same cycle, latch its data into tx_dat, set grant_id, and move to LAUNCH.
REQ-018 Selection: if only one source is valid, pick it; if both are valid, pick the source other than last_grant (round-robin).
REQ-019 last_grant SHALL update only on successful completion (WAIT_DONE->IDLE); it resets to 1, so source 0 wins the first tie.
REQ-020 sX_ready SHALL be 0 in every state other than IDLE; a maximum of one ready SHALL be high per cycle.
REQ-021 LAUNCH: tx_en=1 for exactly this cycle; go to WAIT_BUSY; clear the timeout counter.
REQ-022 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; otherwise increment the timeout counter; when it reaches BUSY_TMO-1 without busy, pulse err_tmo for 1 cycle and go to IDLE without counting the byte.
REQ-023 WAIT_DONE: tx_busy=0 -> IDLE; increment cnt0 or cnt1 according to grant_id; update last_grant.
REQ-024 cnt0 and cnt1 SHALL wrap modulo 2^CNT_W without saturation or flag.
REQ-025 tx_dat SHALL hold the latched byte from LAUNCH until the next acceptance; it SHALL NOT follow sX_data.
REQ-026 active SHALL be 1 in LAUNCH, WAIT_BUSY, and WAIT_DONE, and 0 in IDLE.
REQ-027 Latency: accept at cycle T; tx_en at T+1; busy expected at T+3; next accept no earlier than the cycle busy is sampled low in WAIT_DONE, plus 1.
REQ-028 A valid deasserted without ready is a protocol violation and needs no defined behaviour; a valid that arrives while the block is busy SHALL wait with no loss.
REQ-029 tx_busy high while in IDLE SHALL be ignored, with no acceptance block and no error.

Reset
REQ-030 rst_n low SHALL force the following asynchronously: state IDLE; tx_en=0, tx_dat=8'h00, active=0, grant_id=0, err_tmo=0, cnt0=cnt1=0, last_grant=1, timeout counter 0.
REQ-031 Reset mid-transfer SHALL abandon the byte and not count it; after release, the first cycle is IDLE.
REQ-032 While rst_n is low, s0_ready and s1_ready SHALL be 0.

Verification
REQ-033 Single: s0_valid with 8'hA5 at T -> s0_ready at T, tx_en at T+1 with tx_dat=8'hA5, active until busy falls, then cnt0=1.
REQ-034 Tie: both valid from reset with 8'h11/8'h22 -> order is 11, 22, 11, 22...; grant_id alternates 0,1,0,1; cnt0=cnt1 after each pair.
REQ-035 Hold-off: s1_valid asserted during WAIT_DONE of s0 -> no s1_ready until IDLE; s1 byte sent next, not lost.
REQ-036 Timeout: tx_busy tied 0, s0 sends 8'h3C -> err_tmo pulse exactly BUSY_TMO cycles after tx_en, cnt0 stays 0, next byte still accepted.
REQ-037 Reset mid-frame: rst_n low during WAIT_DONE -> all outputs at reset values immediately; the counter is not incremented.
REQ-038 Wrap: CNT_W=4, 17 bytes from s1 -> cnt1=1.
